// File: rtl/window_serializer_11.sv
// window_serializer_11: emits an 11-pixel window word one pixel per beat,
// oldest pixel first, with a one-word holding buffer for gapless streaming.
module window_serializer_11 #(
    parameter int PIXELS = 11,
    parameter int W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PIXELS*W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy
);

    localparam int N  = PIXELS * W;
    localparam int CW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CW-1:0] LAST = CW'(PIXELS - 1);

    logic [N-1:0]  act_q, act_d;
    logic [N-1:0]  hold_q, hold_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          act_v_q, act_v_d;
    logic          hold_v_q, hold_v_d;

    logic in_hs;
    logic out_hs;
    logic is_last;

    assign in_ready  = ~hold_v_q;
    assign out_valid = act_v_q;
    assign out_data  = act_q[N-1 -: W];
    assign is_last   = act_v_q & (cnt_q == LAST);
    assign out_last  = is_last;
    assign busy      = act_v_q | hold_v_q;

    assign in_hs  = in_valid & ~hold_v_q;
    assign out_hs = act_v_q & out_ready;

    always_comb begin
        act_d    = act_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        act_v_d  = act_v_q;
        hold_v_d = hold_v_q;
        if (out_hs && is_last) begin
            // Drain: a held word takes priority; hold_v=1 blocks input.
            if (hold_v_q) begin
                act_d    = hold_q;
                cnt_d    = '0;
                hold_v_d = 1'b0;
            end else if (in_hs) begin
                act_d = in_data;
                cnt_d = '0;
            end else begin
                act_v_d = 1'b0;
            end
        end else begin
            if (out_hs) begin
                act_d = act_q << W;
                cnt_d = cnt_q + CW'(1);
            end
            if (in_hs) begin
                if (!act_v_q) begin
                    act_d   = in_data;
                    cnt_d   = '0;
                    act_v_d = 1'b1;
                end else begin
                    hold_d   = in_data;
                    hold_v_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q    <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            act_v_q  <= 1'b0;
            hold_v_q <= 1'b0;
        end else begin
            act_q    <= act_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            act_v_q  <= act_v_d;
            hold_v_q <= hold_v_d;
        end
    end

endmodule
